// File: rtl/button_debounce_pkg.sv
// Shared debounce/timing definitions: FSM state encoding and default
// tick-count constants reused by the tick-driven timing blocks.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } db_state_e;

  // Debounce tick period is 100 us; constants below are in ticks.
  localparam int TICK_100US       = 1;
  localparam int TICKS_PER_SEC    = 10000 * TICK_100US;
  localparam int HOLD_TICKS_DEF   = TICKS_PER_SEC / 2;
  localparam int REPEAT_TICKS_DEF = TICKS_PER_SEC / 10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs,
// with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: tick-sampled stable-count FSM with press/release
// pulses. Optional auto-repeat on long hold: BUTTON_DEBOUNCE_AUTO_REPEAT_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_TICKS   = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int HOLD_TICKS     = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (STABLE_TICKS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
    $error("button_debounce: tick parameters must be >= 1");
  end

  logic pin_s;
  logic act;
  logic tick_q;
  logic tick_rise;

  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  localparam int HW = $clog2(max2(HOLD_TICKS, REPEAT_TICKS) + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] REP_LIM  = HW'(REPEAT_TICKS);

  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic rep_q, rep_d;
`endif

  // Idle pin level on reset, so a held button reads as released.
  sync_2ff #(
    .RST_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (pin_s)
  );

  assign act       = BTN_ACTIVE_LOW ? ~pin_s : pin_s;
  assign tick_rise = tick_in & ~tick_q;
  assign cnt_inc   = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    hold_d   = hold_q;
    rep_d    = rep_q;
    hold_inc = hold_q + 1'b1;
`endif
    if (tick_rise) begin
      unique case (state_q)
        ST_RELEASED: begin
          if (act) begin
            if (STABLE_TICKS == 1) begin
              state_d = ST_PRESSED;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = ST_PRESS_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!act) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!act) begin
            if (STABLE_TICKS == 1) begin
              state_d = ST_RELEASED;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = ST_RELEASE_CHK;
              cnt_d   = CNT_ONE;
            end
          end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
          else if (hold_inc == (rep_q ? REP_LIM : HOLD_LIM)) begin
            press_d = 1'b1;
            hold_d  = '0;
            rep_d   = 1'b1;
          end else begin
            hold_d = hold_inc;
          end
`endif
        end
        ST_RELEASE_CHK: begin
          if (act) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_RELEASED;
            level_d = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    // Repeat timing only runs while continuously in PRESSED.
    if (state_q != ST_PRESSED || state_d != ST_PRESSED) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= 1'b1;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      tick_q  <= tick_in;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: STABLE_TICKS=4 and =1 instances share stimulus;
// a run-length model checks both every cycle, plus literal timing checks.
module tb_button_debounce;

  localparam int HOLD = 10;
  localparam int REP  = 3;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick_in;
  logic btn_in;
  logic [1:0] lvl, prs, rls;

  int vec = 0;
  int err = 0;
  int tick_cnt = 0;
  int tick_mode = 0;
  int pc[2], rc[2], ptick[2];

  always #5 clk = ~clk;

  button_debounce #(
    .STABLE_TICKS (4), .BTN_ACTIVE_LOW (1'b1),
    .HOLD_TICKS (HOLD), .REPEAT_TICKS (REP)
  ) u_dut4 (
    .clk (clk), .rst (rst), .tick_in (tick_in), .btn_in (btn_in),
    .btn_level (lvl[0]), .press_pulse (prs[0]), .release_pulse (rls[0])
  );

  button_debounce #(
    .STABLE_TICKS (1), .BTN_ACTIVE_LOW (1'b1),
    .HOLD_TICKS (HOLD), .REPEAT_TICKS (REP)
  ) u_dut1 (
    .clk (clk), .rst (rst), .tick_in (tick_in), .btn_in (btn_in),
    .btn_level (lvl[1]), .press_pulse (prs[1]), .release_pulse (rls[1])
  );

  // 256-clk tick square wave, or stuck high/low.
  initial begin : tick_gen
    logic [7:0] tph;
    tph = 8'd0;
    tick_in = 1'b1;
    forever begin
      @(negedge clk);
      tph = tph + 8'd1;
      case (tick_mode)
        1: tick_in = 1'b1;
        2: tick_in = 1'b0;
        default: tick_in = ~tph[7];
      endcase
    end
  end

  // Model: level flips after N consecutive opposite samples.
  initial begin : model
    int nst[2];
    int run[2];
    int held[2];
    bit mlvl[2], mp[2], mr[2];
    bit p1, p2, prev_tin, a, rise, tin, pin;
    nst[0] = 4;
    nst[1] = 1;
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; held[i] = 0; mlvl[i] = 0; mp[i] = 0; mr[i] = 0;
      pc[i] = 0; rc[i] = 0; ptick[i] = 0;
    end
    p1 = 1; p2 = 1; prev_tin = 1;
    forever begin
      @(posedge clk);
      tin = tick_in;
      pin = btn_in;
      for (int i = 0; i < 2; i++) begin
        mp[i] = 0;
        mr[i] = 0;
      end
      if (rst) begin
        p1 = 1; p2 = 1; prev_tin = 1;
        for (int i = 0; i < 2; i++) begin
          run[i] = 0; held[i] = 0; mlvl[i] = 0;
        end
      end else begin
        a = (p2 == 1'b0);
        rise = tin && !prev_tin;
        prev_tin = tin;
        p2 = p1;
        p1 = pin;
        if (rise) begin
          tick_cnt++;
          for (int i = 0; i < 2; i++) begin
            if (!mlvl[i]) begin
              run[i] = a ? run[i] + 1 : 0;
              if (run[i] == nst[i]) begin
                mlvl[i] = 1; mp[i] = 1; run[i] = 0; held[i] = 0;
              end
            end else begin
              run[i] = !a ? run[i] + 1 : 0;
              if (run[i] == nst[i]) begin
                mlvl[i] = 0; mr[i] = 1; run[i] = 0;
              end else if (REP_ON) begin
                if (!a) held[i] = -1;
                else begin
                  held[i]++;
                  if (held[i] >= HOLD && (held[i] - HOLD) % REP == 0)
                    mp[i] = 1;
                end
              end
            end
          end
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        vec++;
        if ({lvl[i], prs[i], rls[i]} !== {mlvl[i], mp[i], mr[i]}) begin
          err++;
          $display("FAIL model_dut%0d t=%0t got lvl/prs/rls=%b exp=%b",
                   i, $time, {lvl[i], prs[i], rls[i]},
                   {mlvl[i], mp[i], mr[i]});
        end
        if (prs[i] === 1'b1) begin
          pc[i]++;
          ptick[i] = tick_cnt;
        end
        if (rls[i] === 1'b1) rc[i]++;
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    int target;
    target = tick_cnt + n;
    for (int k = 0; k < n * 300 && tick_cnt < target; k++)
      @(negedge clk);
    if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
  endtask

  initial begin : stim
    int s, sp0, sp1, sr0, sr1;
    int exp4, exp1, last4;
    btn_in = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_lvl4", lvl[0], 0);
    check("rst_prs4", prs[0], 0);
    check("rst_rls1", rls[1], 0);
    rst = 1'b0;
    ticks(1);

    // clean press
    sp0 = pc[0]; sp1 = pc[1]; sr0 = rc[0];
    btn_in = 1'b0; s = tick_cnt;
    ticks(6);
    check("press_cnt4", pc[0] - sp0, 1);
    check("press_at4", ptick[0] - s, 4);
    check("press_at1", ptick[1] - s, 1);
    check("press_cnt1", pc[1] - sp1, 1);
    check("press_lvl4", lvl[0], 1);
    check("press_rel4", rc[0] - sr0, 0);

    // clean release
    sp0 = pc[0]; sr0 = rc[0]; sr1 = rc[1];
    btn_in = 1'b1;
    ticks(4);
    check("rel_cnt4", rc[0] - sr0, 1);
    check("rel_cnt1", rc[1] - sr1, 1);
    check("rel_prs4", pc[0] - sp0, 0);
    check("rel_lvl4", lvl[0], 0);

    // bounce: 3 low, 1 high, five times
    sp0 = pc[0]; sp1 = pc[1]; sr1 = rc[1];
    for (int r = 0; r < 5; r++) begin
      btn_in = 1'b0; ticks(3);
      btn_in = 1'b1; ticks(1);
    end
    check("bounce_prs4", pc[0] - sp0, 0);
    check("bounce_lvl4", lvl[0], 0);
    check("bounce_prs1", pc[1] - sp1, 5);
    check("bounce_rel1", rc[1] - sr1, 5);
    btn_in = 1'b0; s = tick_cnt;
    ticks(4);
    check("bounce_hold4", pc[0] - sp0, 1);
    check("bounce_at4", ptick[0] - s, 4);
    btn_in = 1'b1;
    ticks(4);

    // reset mid-debounce, pin held, tick high at release
    btn_in = 1'b0;
    ticks(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_lvl1", lvl[1], 0);
    check("arst_lvl4", lvl[0], 0);
    for (int k = 0; k < 300 && tick_in !== 1'b1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    sp0 = pc[0]; sp1 = pc[1];
    rst = 1'b0; s = tick_cnt;
    ticks(5);
    check("rstrel_cnt4", pc[0] - sp0, 1);
    check("rstrel_at4", ptick[0] - s, 4);
    check("rstrel_cnt1", pc[1] - sp1, 1);
    check("rstrel_at1", ptick[1] - s, 1);
    btn_in = 1'b1;
    ticks(5);

    // tick stuck high: frozen
    tick_mode = 1;
    sp0 = pc[0]; sp1 = pc[1];
    btn_in = 1'b0;
    repeat (600) @(negedge clk);
    check("stuck_prs4", pc[0] - sp0, 0);
    check("stuck_prs1", pc[1] - sp1, 0);
    check("stuck_lvl1", lvl[1], 0);
    btn_in = 1'b1;
    repeat (10) @(negedge clk);
    tick_mode = 0;
    ticks(1);

    // long hold
    exp4 = REP_ON ? 5 : 1;
    exp1 = REP_ON ? 6 : 1;
    last4 = REP_ON ? 23 : 4;
    sp0 = pc[0]; sp1 = pc[1];
    btn_in = 1'b0; s = tick_cnt;
    ticks(24);
    check("hold_cnt4", pc[0] - sp0, exp4);
    check("hold_cnt1", pc[1] - sp1, exp1);
    check("hold_last4", ptick[0] - s, last4);
    sp0 = pc[0]; sr0 = rc[0]; sr1 = rc[1];
    btn_in = 1'b1;
    ticks(4);
    check("hold_rel4", rc[0] - sr0, 1);
    check("hold_rel1", rc[1] - sr1, 1);
    check("hold_relprs4", pc[0] - sp0, 0);
    check("hold_rellvl4", lvl[0], 0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
